// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: the pipeline WB stage always wins, and MDU results queue in a FIFO.
// A busy scoreboard tracks MDU destinations in flight. Define WB_ARB_ANTISTARVE_EN to build the stall_wb wait counter.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pipe_we,
  input  logic [4:0]                 pipe_rd,
  input  logic [31:0]                pipe_data,
  input  logic                       mdu_issue_valid,
  input  logic [4:0]                 mdu_issue_rd,
  output logic                       mdu_issue_ready,
  input  logic                       mdu_res_valid,
  input  logic [4:0]                 mdu_res_rd,
  input  logic [31:0]                mdu_res_data,
  output logic                       mdu_res_ready,
  output logic                       rf_we3,
  output logic [4:0]                 rf_addr3,
  output logic [31:0]                rf_write3,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  output logic                       busy_rs1,
  output logic                       busy_rs2,
  output logic                       stall_wb,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || MAX_WAIT < 1) begin : g_cfg_check
    $error("regfile_wb_arbiter: DEPTH and MAX_WAIT must be at least 1");
  end

  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;
  logic             issue_fire;
  logic             sel_valid;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;

  assign head_rd         = rd_mem[rd_ptr];
  assign head_data       = data_mem[rd_ptr];
  assign mdu_res_ready   = (level != LVL_W'(DEPTH));
  assign push            = mdu_res_valid && mdu_res_ready;
  assign mdu_issue_ready = !busy[mdu_issue_rd];
  assign issue_fire      = mdu_issue_valid && mdu_issue_ready;
  assign busy_rs1        = busy[q_rs1];
  assign busy_rs2        = busy[q_rs2];
  assign fifo_level      = level;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    pop       = 1'b0;
    if (pipe_we) begin
      sel_valid = 1'b1;
      sel_rd    = pipe_rd;
      sel_data  = pipe_data;
    end else if (level != '0) begin
      sel_valid = 1'b1;
      sel_rd    = head_rd;
      sel_data  = head_data;
      pop       = 1'b1;
    end
  end

  // A head entry addressed to x0 still pops, but it never reaches the port.
  assign rf_we3    = sel_valid && (sel_rd != '0);
  assign rf_addr3  = rf_we3 ? sel_rd : '0;
  assign rf_write3 = rf_we3 ? sel_data : '0;

  // The clear is applied before the set, so a set wins on the same register.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_rd] = 1'b0;
    if (issue_fire) busy_next[mdu_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= mdu_res_rd;
      data_mem[wr_ptr] <= mdu_res_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

`ifdef WB_ARB_ANTISTARVE_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (pop || level == '0)
        wait_cnt <= '0;
      else if (pipe_we && wait_cnt != CNT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
      if (pop)
        stall_q <= 1'b0;
      else if (wait_cnt == CNT_W'(MAX_WAIT))
        stall_q <= 1'b1;
    end
  end

  assign stall_wb = stall_q;
`else
  assign stall_wb = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (DEPTH=2, MAX_WAIT=4), plus hand-written
// sequences covering reset during operation and the stall_wb behaviour.
module tb_regfile_wb_arbiter;

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        iv;
    logic [4:0]  ird;
    logic        rv;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        ewe;
    logic [4:0]  eaddr;
    logic [31:0] edata;
    logic        eir;
    logic        err;
    logic        eb1;
    logic        eb2;
    logic [1:0]  elvl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        mdu_issue_valid = 1'b0;
  logic [4:0]  mdu_issue_rd = '0;
  logic        mdu_issue_ready;
  logic        mdu_res_valid = 1'b0;
  logic [4:0]  mdu_res_rd = '0;
  logic [31:0] mdu_res_data = '0;
  logic        mdu_res_ready;
  logic        rf_we3;
  logic [4:0]  rf_addr3;
  logic [31:0] rf_write3;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        stall_wb;
  logic [1:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [24];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_issue_valid(mdu_issue_valid), .mdu_issue_rd(mdu_issue_rd), .mdu_issue_ready(mdu_issue_ready),
    .mdu_res_valid(mdu_res_valid), .mdu_res_rd(mdu_res_rd), .mdu_res_data(mdu_res_data),
    .mdu_res_ready(mdu_res_ready),
    .rf_we3(rf_we3), .rf_addr3(rf_addr3), .rf_write3(rf_write3),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .stall_wb(stall_wb), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipe_we = v.pwe; pipe_rd = v.prd; pipe_data = v.pdata;
    mdu_issue_valid = v.iv; mdu_issue_rd = v.ird;
    mdu_res_valid = v.rv; mdu_res_rd = v.rrd; mdu_res_data = v.rdata;
    q_rs1 = v.q1; q_rs2 = v.q2;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mdu_issue_valid = 0; mdu_issue_rd = 0;
    mdu_res_valid = 0; mdu_res_rd = 0; mdu_res_data = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pwe prd pdata         iv ird rv rrd rdata         q1  q2   we addr wdata         ir rr b1 b2 lvl
    vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0, 0,  32'h0,        7,  5,   1, 5,  32'hDEADBEEF, 1, 1, 0, 0, 0};
    vecs[1]  = '{0, 0,  32'h0,        1, 7,  0, 0,  32'h0,        7,  5,   0, 0,  32'h0,        1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0,  32'h0,        1, 7,  0, 0,  32'h0,        7,  5,   0, 0,  32'h0,        0, 1, 1, 0, 0};
    vecs[3]  = '{0, 0,  32'h0,        0, 7,  1, 7,  32'h12345678, 7,  5,   0, 0,  32'h0,        0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0,  32'h0,        0, 7,  0, 0,  32'h0,        7,  5,   1, 7,  32'h12345678, 0, 1, 1, 0, 1};
    vecs[5]  = '{0, 0,  32'h0,        0, 7,  0, 0,  32'h0,        7,  5,   0, 0,  32'h0,        1, 1, 0, 0, 0};
    vecs[6]  = '{1, 9,  32'h9,        1, 3,  0, 0,  32'h0,        3,  4,   1, 9,  32'h9,        1, 1, 0, 0, 0};
    vecs[7]  = '{1, 10, 32'hA,        1, 4,  0, 0,  32'h0,        3,  4,   1, 10, 32'hA,        1, 1, 1, 0, 0};
    vecs[8]  = '{1, 11, 32'hB,        0, 3,  1, 3,  32'h33,       3,  4,   1, 11, 32'hB,        0, 1, 1, 1, 0};
    vecs[9]  = '{1, 12, 32'hC,        0, 4,  1, 4,  32'h44,       3,  4,   1, 12, 32'hC,        0, 1, 1, 1, 1};
    vecs[10] = '{1, 13, 32'hD,        0, 0,  1, 5,  32'h55,       3,  4,   1, 13, 32'hD,        1, 0, 1, 1, 2};
    vecs[11] = '{0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        3,  4,   1, 3,  32'h33,       1, 0, 1, 1, 2};
    vecs[12] = '{0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        3,  4,   1, 4,  32'h44,       1, 1, 0, 1, 1};
    vecs[13] = '{0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        3,  4,   0, 0,  32'h0,        1, 1, 0, 0, 0};
    vecs[14] = '{0, 0,  32'h0,        1, 0,  1, 0,  32'hFF,       0,  0,   0, 0,  32'h0,        1, 1, 0, 0, 0};
    vecs[15] = '{0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        1, 1, 0, 0, 1};
    vecs[16] = '{1, 0,  32'h77,       0, 0,  0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        1, 1, 0, 0, 0};
    vecs[17] = '{0, 0,  32'h0,        0, 0,  1, 20, 32'hA0,       20, 24,  0, 0,  32'h0,        1, 1, 0, 0, 0};
    vecs[18] = '{0, 0,  32'h0,        0, 0,  1, 21, 32'hA1,       20, 24,  1, 20, 32'hA0,       1, 1, 0, 0, 1};
    vecs[19] = '{0, 0,  32'h0,        0, 0,  1, 22, 32'hA2,       20, 24,  1, 21, 32'hA1,       1, 1, 0, 0, 1};
    vecs[20] = '{0, 0,  32'h0,        0, 0,  1, 23, 32'hA3,       20, 24,  1, 22, 32'hA2,       1, 1, 0, 0, 1};
    vecs[21] = '{0, 0,  32'h0,        0, 0,  1, 24, 32'hA4,       20, 24,  1, 23, 32'hA3,       1, 1, 0, 0, 1};
    vecs[22] = '{0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        20, 24,  1, 24, 32'hA4,       1, 1, 0, 0, 1};
    vecs[23] = '{0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        20, 24,  0, 0,  32'h0,        1, 1, 0, 0, 0};

    // Reset state, checked while reset is held.
    #2;
    n_vec++;
    chk("reset_we3", -1, 32'(rf_we3), 32'd0);
    chk("reset_level", -1, 32'(fifo_level), 32'd0);
    chk("reset_res_ready", -1, 32'(mdu_res_ready), 32'd1);
    chk("reset_stall", -1, 32'(stall_wb), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      n_vec++;
      chk("rf_we3", i, 32'(rf_we3), 32'(vecs[i].ewe));
      chk("rf_addr3", i, 32'(rf_addr3), 32'(vecs[i].eaddr));
      chk("rf_write3", i, rf_write3, vecs[i].edata);
      chk("issue_ready", i, 32'(mdu_issue_ready), 32'(vecs[i].eir));
      chk("res_ready", i, 32'(mdu_res_ready), 32'(vecs[i].err));
      chk("busy_rs1", i, 32'(busy_rs1), 32'(vecs[i].eb1));
      chk("busy_rs2", i, 32'(busy_rs2), 32'(vecs[i].eb2));
      chk("fifo_level", i, 32'(fifo_level), 32'(vecs[i].elvl));
      chk("stall_wb", i, 32'(stall_wb), 32'd0);
    end

    // Reset in the middle of operation drops the queued entry and the pending busy bit.
    @(negedge clk);
    idle();
    pipe_we = 1; pipe_rd = 1; pipe_data = 32'h1;
    mdu_issue_valid = 1; mdu_issue_rd = 15;
    mdu_res_valid = 1; mdu_res_rd = 15; mdu_res_data = 32'hF;
    @(negedge clk);
    idle();
    q_rs1 = 15;
    #1;
    n_vec++;
    chk("pre_reset_level", 100, 32'(fifo_level), 32'd1);
    chk("pre_reset_busy", 100, 32'(busy_rs1), 32'd1);
    reset_n = 1'b0;
    #1;
    n_vec++;
    chk("mid_reset_level", 101, 32'(fifo_level), 32'd0);
    chk("mid_reset_busy", 101, 32'(busy_rs1), 32'd0);
    chk("mid_reset_we3", 101, 32'(rf_we3), 32'd0);
    chk("mid_reset_res_ready", 101, 32'(mdu_res_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // One queued result blocked by pipeline writes for six cycles, then released.
    @(negedge clk);
    pipe_we = 1; pipe_rd = 1; pipe_data = 32'h1;
    mdu_res_valid = 1; mdu_res_rd = 6; mdu_res_data = 32'h66;
    for (int b = 1; b <= 8; b++) begin
      logic exp_stall;
      @(negedge clk);
      mdu_res_valid = 0;
      pipe_we = (b <= 6);
      #1;
`ifdef WB_ARB_ANTISTARVE_EN
      exp_stall = (b == 6 || b == 7);
`else
      exp_stall = 1'b0;
`endif
      n_vec++;
      chk("stall_wb_seq", 200 + b, 32'(stall_wb), 32'(exp_stall));
      chk("starve_level", 200 + b, 32'(fifo_level), (b <= 7) ? 32'd1 : 32'd0);
      if (b == 7) begin
        chk("starve_pop_addr", 207, 32'(rf_addr3), 32'd6);
        chk("starve_pop_data", 207, rf_write3, 32'h66);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
